// File: rtl/serial_adder.sv
// ============================================================================
// Module   : serial_adder
// Purpose  : Bit-serial WIDTH-bit adder (one full-adder cell plus carry FF),
//            LSB first, with start/busy/done handshake.
// Option   : define SERIAL_ADD_CIN_EN to add the cin port (result a+b+cin).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_CIN_EN
  input  logic             cin,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
    $error("serial_adder: WIDTH must be in 2..32");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] psum;
  logic             c;
  logic [CNT_W-1:0] cnt;

  logic             bit_sum;
  logic             bit_carry;
  logic             carry_init;
  logic [WIDTH-1:0] psum_next;

  // The single full-adder cell shared by every bit position
  assign bit_sum   = ra[0] ^ rb[0] ^ c;
  assign bit_carry = (ra[0] & rb[0]) | (ra[0] & c) | (rb[0] & c);
  assign psum_next = {bit_sum, psum[WIDTH-1:1]};

`ifdef SERIAL_ADD_CIN_EN
  assign carry_init = cin;
`else
  assign carry_init = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      psum  <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      carry <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            ra    <= a;
            rb    <= b;
            c     <= carry_init;
            cnt   <= '0;
            psum  <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          ra   <= ra >> 1;
          rb   <= rb >> 1;
          psum <= psum_next;
          c    <= bit_carry;
          // Outputs change only here, so sum/carry hold the previous result during SHIFT
          if (cnt == LAST_BIT) begin
            sum   <= psum_next;
            carry <= bit_carry;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module   : tb_serial_adder
// Purpose  : Self-checking bench for serial_adder (WIDTH=8): directed table,
//            multi-cycle corner sequences and randomized vectors vs. a+b(+cin).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] prev_sum = '0;
  logic         prev_carry = 1'b0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         c;
  } vec_t;

  vec_t vecs[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_ADD_CIN_EN
    .cin   (cin),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .carry (carry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Called right after a negedge. Runs one addition through to the idle cycle after
  // done, leaving the bench at the negedge where the next start is legal.
  task automatic run_add(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tc, input logic [W-1:0] es, input logic ec,
                         input bit hold_start);
    start = 1'b1;
    a     = ta;
    b     = tb_v;
    cin   = tc;
    for (int i = 1; i <= W + 2; i++) begin
      @(negedge clk);
      if (i == 1) begin
        if (hold_start) begin
          a = '1;
          b = '1;
        end else begin
          start = 1'b0;
          a = W'($urandom);
          b = W'($urandom);
        end
        cin = ~tc;
      end
      if (hold_start && i == W + 1) start = 1'b0;
      if (i <= W) begin
        chk("done_low_in_shift", {31'b0, done}, 32'd0);
        chk("busy_in_shift", {31'b0, busy}, 32'd1);
        chk("sum_hold", {24'b0, sum}, {24'b0, prev_sum});
        chk("carry_hold", {31'b0, carry}, {31'b0, prev_carry});
      end else if (i == W + 1) begin
        chk("done_pulse", {31'b0, done}, 32'd1);
        chk("busy_in_done", {31'b0, busy}, 32'd1);
        chk("sum", {24'b0, sum}, {24'b0, es});
        chk("carry", {31'b0, carry}, {31'b0, ec});
      end else begin
        chk("done_cleared", {31'b0, done}, 32'd0);
        chk("busy_cleared", {31'b0, busy}, 32'd0);
      end
    end
    prev_sum   = es;
    prev_carry = ec;
  endtask

  // Reference: plain (W+1)-bit addition
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                      input logic ci);
    logic eff_cin;
`ifdef SERIAL_ADD_CIN_EN
    eff_cin = ci;
`else
    eff_cin = 1'b0;
`endif
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, eff_cin};
  endfunction

  initial begin
    logic [W-1:0] ra_v, rb_v;
    logic         rc_v;
    logic [W:0]   ref_v;

    vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0});
    vecs.push_back('{8'h80, 8'h80, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1});
    vecs.push_back('{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0});
    vecs.push_back('{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0});
`ifdef SERIAL_ADD_CIN_EN
    vecs.push_back('{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1});
    vecs.push_back('{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0});
    vecs.push_back('{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1});
`endif

    // Reset state
    rst = 1'b1;
    start = 1'b1;
    a = 8'h11;
    b = 8'h22;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_sum", {24'b0, sum}, 32'd0);
    chk("reset_carry", {31'b0, carry}, 32'd0);
    @(negedge clk);

    // Directed table, applied back-to-back at the earliest legal start
    foreach (vecs[i]) run_add(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].c, 1'b0);

    // start held high with different operands while busy: only one result
    run_add(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_second_done", {31'b0, done}, 32'd0);
      chk("no_second_busy", {31'b0, busy}, 32'd0);
    end

    // Reset mid-operation
    start = 1'b1;
    a = 8'hF0;
    b = 8'h0F;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_sum", {24'b0, sum}, 32'd0);
    chk("abort_carry", {31'b0, carry}, 32'd0);
    prev_sum = '0;
    prev_carry = 1'b0;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", {31'b0, done}, 32'd0);
    end
    run_add(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

    // Randomized vectors against the arithmetic model
    for (int n = 0; n < 40; n++) begin
      ra_v  = W'($urandom);
      rb_v  = W'($urandom);
      rc_v  = 1'($urandom);
      ref_v = model(ra_v, rb_v, rc_v);
      run_add(ra_v, rb_v, rc_v, ref_v[W-1:0], ref_v[W], 1'b0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
